// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle link into and out of one pipeline stage register.
// master = upstream producer plus downstream consumer; slave = the stage itself.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush that clears only CLEAR_MASK bits; 1-cycle latency.
// SKID=1 adds a second entry so in_ready is registered; SKID=0 passes backpressure combinationally.
module pipe_stage_reg #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] CLEAR_MASK = {WIDTH{1'b1}},
    parameter int               SKID       = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipe_stage_reg_if.slave    bus,
    output logic [1:0]         occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             in_rdy;
    logic             it, ot;

    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = main_q;
    assign in_rdy        = (SKID != 0) ? in_ready_q : (!bus.out_valid || bus.out_ready);
    assign bus.in_ready  = in_rdy;
    assign it            = bus.in_valid && in_rdy;
    assign ot            = bus.out_valid && bus.out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Control fields are zeroed, datapath fields survive for debug visibility.
            state_d = EMPTY;
            main_d  = main_q & ~CLEAR_MASK;
            skid_d  = skid_q & ~CLEAR_MASK;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (it) begin
                        main_d  = bus.in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (it && ot) begin
                        main_d = bus.in_data;
                    end else if (it && (SKID != 0)) begin
                        skid_d  = bus.in_data;
                        state_d = FULL;
                    end else if (ot) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (ot) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scenario tasks against a SKID=1 / low-byte-mask stage (a) and a SKID=0 / full-mask stage (b).
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    logic [1:0] occ_a, occ_b;

    int errors = 0;
    int checks = 0;
    int dlv_a  = 0;
    int dlv_b  = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] ea, eb;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.WIDTH(32)) ia ();
    pipe_stage_reg_if #(.WIDTH(32)) ib ();

    pipe_stage_reg #(.WIDTH(32), .CLEAR_MASK(32'h0000_00FF), .SKID(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .bus(ia.slave), .occupancy(occ_a)
    );

    pipe_stage_reg #(.WIDTH(32), .CLEAR_MASK(32'hFFFF_FFFF), .SKID(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .bus(ib.slave), .occupancy(occ_b)
    );

    initial begin
        ia.in_valid = 1'b0; ia.in_data = '0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.out_ready = 1'b0;
    end

    // Scoreboard: handshakes are sampled mid-cycle, mirroring what the next edge will do.
    always @(negedge clk) begin
        if (!rst) begin
            qa.delete();
        end else begin
            if (ia.out_valid && ia.out_ready) begin
                checks++;
                dlv_a++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL sb_a_unexpected: got %h, expected no output", ia.out_data);
                end else begin
                    ea = qa.pop_front();
                    if (ia.out_data !== ea) begin
                        errors++;
                        $display("FAIL sb_a_order: got %h, expected %h", ia.out_data, ea);
                    end
                end
            end
            if (flush_a) qa.delete();
            else if (ia.in_valid && ia.in_ready) qa.push_back(ia.in_data);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            qb.delete();
        end else begin
            if (ib.out_valid && ib.out_ready) begin
                checks++;
                dlv_b++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_b_unexpected: got %h, expected no output", ib.out_data);
                end else begin
                    eb = qb.pop_front();
                    if (ib.out_data !== eb) begin
                        errors++;
                        $display("FAIL sb_b_order: got %h, expected %h", ib.out_data, eb);
                    end
                end
            end
            if (flush_b) qb.delete();
            else if (ib.in_valid && ib.in_ready) qb.push_back(ib.in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", ia.out_valid); end
        checks++; if (ia.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h, expected 0", ia.out_data); end
        checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, expected 1", ia.in_ready); end
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL rst_occupancy: got %0d, expected 0", occ_a); end
        checks++; if (ib.in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_in_ready: got %b, expected 1", ib.in_ready); end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        ia.in_valid = 1'b1; ia.in_data = 32'hDEAD_BEEF; ia.out_ready = 1'b1;
        tick();
        ia.in_valid = 1'b0;
        checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b, expected 1", ia.out_valid); end
        checks++; if (ia.out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_data: got %h, expected deadbeef", ia.out_data); end
        checks++; if (occ_a !== 2'd1) begin errors++; $display("FAIL basic_occupancy: got %0d, expected 1", occ_a); end
        tick();
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL basic_drain: got %0d, expected 0", occ_a); end
    endtask

    task automatic test_skid_fill();
        int d0;
        d0 = dlv_a;
        ia.out_ready = 1'b0;
        ia.in_valid = 1'b1; ia.in_data = 32'h11;
        tick();
        ia.in_data = 32'h22;
        tick();
        ia.in_valid = 1'b0;
        checks++; if (occ_a !== 2'd2) begin errors++; $display("FAIL skid_occupancy: got %0d, expected 2", occ_a); end
        checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready: got %b, expected 0", ia.in_ready); end
        tick();
        checks++; if (ia.out_data !== 32'h11) begin errors++; $display("FAIL skid_hold: got %h, expected 11", ia.out_data); end
        ia.out_ready = 1'b1;
        tick();
        checks++; if (ia.out_data !== 32'h22) begin errors++; $display("FAIL skid_second: got %h, expected 22", ia.out_data); end
        tick();
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL skid_drained: got %0d, expected 0", occ_a); end
        checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %b, expected 1", ia.in_ready); end
        checks++; if (dlv_a - d0 !== 2) begin errors++; $display("FAIL skid_count: got %0d, expected 2", dlv_a - d0); end
    endtask

    task automatic test_streaming();
        int d0;
        d0 = dlv_a;
        ia.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            ia.in_valid = 1'b1; ia.in_data = i;
            tick();
            checks++; if (occ_a !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d, expected 1", i, occ_a); end
            checks++; if (ia.out_data !== 32'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h, expected %h", i, ia.out_data, i); end
        end
        ia.in_valid = 1'b0;
        tick();
        checks++; if (dlv_a - d0 !== 8) begin errors++; $display("FAIL stream_count: got %0d, expected 8", dlv_a - d0); end
    endtask

    task automatic test_flush();
        ia.out_ready = 1'b0;
        ia.in_valid = 1'b1; ia.in_data = 32'hAAAA_AAAA;
        tick();
        ia.in_data = 32'h5555_5555;
        tick();
        flush_a = 1'b1; ia.in_data = 32'h77;
        tick();
        flush_a = 1'b0; ia.in_valid = 1'b0;
        checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, expected 0", ia.out_valid); end
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d, expected 0", occ_a); end
        checks++; if (ia.out_data !== 32'hAAAA_AA00) begin errors++; $display("FAIL flush_main: got %h, expected aaaaaa00", ia.out_data); end
        checks++; if (dut_a.skid_q !== 32'h5555_5500) begin errors++; $display("FAIL flush_skid: got %h, expected 55555500", dut_a.skid_q); end
        checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b, expected 1", ia.in_ready); end
        ia.out_ready = 1'b1;
        tick();
        tick();
        checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_replay: got %b, expected 0", ia.out_valid); end
    endtask

    task automatic test_stall_flush();
        int d0;
        ib.out_ready = 1'b0;
        ib.in_valid = 1'b1; ib.in_data = 32'hC0DE;
        tick();
        ib.in_data = 32'h0BAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ib.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b, expected 0", i, ib.in_ready); end
            checks++; if (ib.out_data !== 32'hC0DE) begin errors++; $display("FAIL stall_data[%0d]: got %h, expected c0de", i, ib.out_data); end
        end
        d0 = dlv_b;
        flush_b = 1'b1; ib.out_ready = 1'b1;
        tick();
        flush_b = 1'b0; ib.in_valid = 1'b0;
        checks++; if (ib.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ot_valid: got %b, expected 0", ib.out_valid); end
        tick();
        tick();
        checks++; if (dlv_b - d0 !== 1) begin errors++; $display("FAIL flush_ot_once: got %0d, expected 1", dlv_b - d0); end
        checks++; if (occ_b !== 2'd0) begin errors++; $display("FAIL flush_ot_occ: got %0d, expected 0", occ_b); end
    endtask

    task automatic test_reset_mid();
        ia.out_ready = 1'b0;
        ia.in_valid = 1'b1; ia.in_data = 32'h1234_5678;
        tick();
        ia.in_data = 32'h9ABC_DEF0;
        tick();
        ia.in_valid = 1'b0;
        checks++; if (occ_a !== 2'd2) begin errors++; $display("FAIL rmid_full: got %0d, expected 2", occ_a); end
        rst = 1'b0; flush_a = 1'b1;
        tick();
        rst = 1'b1; flush_a = 1'b0;
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL rmid_occ: got %0d, expected 0", occ_a); end
        checks++; if (ia.out_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h, expected 0", ia.out_data); end
        checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b, expected 1", ia.in_ready); end
        checks++; if (dut_a.skid_q !== 32'h0) begin errors++; $display("FAIL rmid_skid: got %h, expected 0", dut_a.skid_q); end
        ia.out_ready = 1'b1;
        tick();
        tick();
        checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_output: got %b, expected 0", ia.out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skid_fill();
        test_streaming();
        test_flush();
        test_stall_flush();
        test_reset_mid();
        checks++; if (qa.size() + qb.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d, expected 0", qa.size() + qb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register; the successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the RV32I pipeline.
- Carries an arbitrary WIDTH-bit packed bundle with a valid/ready handshake, replacing the bare enable.
- Supports flush with selective field clearing, so control bits (RegWrite, MemWrite, etc.) zero while datapath bits are kept.
- Optional 2-entry skid buffer, so in_ready is registered and stage-to-stage timing paths are cut.

Parameters:
- WIDTH, 32, bit width of the packed payload bundle.
- CLEAR_MASK, 32'hFFFF_FFFF, WIDTH-bit mask. Bits set to 1 are forced to 0 in every stored entry on flush. Bits set to 0 keep their value.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready. 0 = single-entry register with combinational in_ready.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- flush  input  1  discard all held entries; synchronous.
- in_valid  input  1  upstream has a valid bundle.
- in_ready  output  1  stage accepts a bundle this cycle.
- in_data  input  WIDTH  upstream bundle.
- out_valid  output  1  out_data holds a valid bundle.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  head bundle.
- occupancy  output  2  number of held entries: 0, 1 or 2.

Behaviour:
- Handshakes:
  - Input transfer (IT) = in_valid & in_ready.
  - Output transfer (OT) = out_valid & out_ready.
- Reset (rst=0 at a clk edge):
  - state EMPTY; main and skid registers = 0.
  - out_valid=0, out_data=0, occupancy=0, in_ready=1.
  - Reset takes priority over flush and all handshakes. Reset mid-stream drops every entry.
- Storage: main register (head, drives out_data) and skid register (used only when SKID=1).
- State machine (SKID=1):
  - EMPTY:
    - IT: main<=in_data, go to ONE.
  - ONE:
    - IT & OT: main<=in_data, stay in ONE.
    - IT & !OT: skid<=in_data, go to FULL.
    - !IT & OT: go to EMPTY.
  - FULL:
    - in_ready=0.
    - OT: main<=skid, go to ONE.
- in_ready (SKID=1): registered, equal to (next state != FULL).
- SKID=0:
  - No FULL state; occupancy is never greater than 1.
  - in_ready = !out_valid | out_ready (combinational).
  - IT: main<=in_data. Behaves like the legacy enabled register, but with a handshake.
- Outputs:
  - out_valid = (state != EMPTY); out_data = main.
  - out_data stays stable while out_valid & !out_ready.
  - Bundles leave in strict arrival order, with no duplication or loss.
- Latency: 1 cycle from IT to out_valid when EMPTY. Sustained throughput is 1 bundle per cycle while out_ready=1.
- Flush (rst=1, flush=1):
  - Next state EMPTY; occupancy=0; in_ready=1 next cycle.
  - main <= main & ~CLEAR_MASK; skid <= skid & ~CLEAR_MASK.
  - An IT in the flush cycle is discarded, not stored.
  - An OT in the flush cycle counts as consumed: downstream keeps it and the stage does not replay it.
- Simultaneous events:
  - FULL & OT & in_valid: no IT, since in_ready=0 in FULL.
  - ONE & IT & OT: the new bundle replaces the head in the same edge.
- Width rule: all payload paths are exactly WIDTH bits; there is no truncation or extension.
- No X on outputs after the first reset edge.

Test Plan:
- Reset and basic transfer:
  - Stimulus: rst=0 for 2 cycles, then in_valid=1, in_data=32'hDEAD_BEEF, out_ready=1.
  - Required: after reset out_valid=0, out_data=0, in_ready=1. One cycle after IT: out_valid=1, out_data=32'hDEAD_BEEF, occupancy=1.
- Skid fill and drain (SKID=1):
  - Stimulus: out_ready=0; push 0x11, then 0x22.
  - Required: occupancy=2, in_ready=0, out_data=0x11 held stable. Raise out_ready: 0x11 then 0x22 delivered on consecutive cycles, after which in_ready=1 and occupancy=0.
- Streaming:
  - Stimulus: push 0x1..0x8 back-to-back with out_ready=1.
  - Required: outputs 0x1..0x8 in order, one per cycle, occupancy constant at 1.
- Selective flush:
  - Stimulus: CLEAR_MASK=32'h0000_00FF, FULL with 0xAAAA_AAAA and 0x5555_5555; assert flush together with in_valid=1 carrying 0x77.
  - Required: next cycle out_valid=0, occupancy=0, main=0xAAAA_AA00, skid=0x5555_5500, and 0x77 is never output.
- Backpressure stall and OT-during-flush:
  - Stimulus: SKID=0; hold out_ready=0 for 5 cycles with in_valid=1.
  - Required: in_ready=0 and out_data unchanged for those 5 cycles.
  - Stimulus: then assert flush with out_ready=1.
  - Required: that head is counted as consumed exactly once, and out_valid=0 next cycle.
- Reset mid-operation:
  - Stimulus: rst=0 while FULL and flush=1.
  - Required: next cycle occupancy=0, out_data=0 (not masked residue), in_ready=1.
